alarm_clock_multi: RTL and testbench

- Parametrised successor to the single-alarm clock top.
- Keeps time as seconds, minutes, hours and day-of-week, and holds NA independent alarms, each with its own day-of-week mask.
- Adds a single shared ring/snooze/timeout state machine.
- Runs on a system clock with a 1 Hz tick enable; outputs binary display values, which feed the existing 2-digit 7-segment drivers externally.

---
 rtl/alarm_pkg.sv | 7 +
 rtl/mod_ctr_wrap.sv | 30 +++
 rtl/alarm_clock_multi.sv | 177 +++++++++++++++++
 tb/tb_alarm_clock_multi.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and field widths for the multi-alarm clock.
package alarm_pkg;
   typedef enum logic [1:0] {RUN, TSET, ASET} mode_e;
   typedef enum logic [1:0] {IDLE, RING, SNOOZE} ring_e;
   localparam int TW = 7;
   localparam int DW = 3;
endpackage

// File: rtl/mod_ctr_wrap.sv
// Modulo-N counter: steps when en & cin, wraps N-1 -> 0 and reports the wrap on cout.
module mod_ctr_wrap #(
   parameter int N = 60,
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         cin,
   output logic         cout,
   output logic [W-1:0] q,
   output logic [W-1:0] qn
);
   localparam logic [W-1:0] MAX = W'(N - 1);

   logic step;
   assign step = en & cin;
   assign cout = step & (q == MAX);

   // qn is the value q takes at the next edge, exposed for same-cycle lookahead
   always_comb begin
      qn = q;
      if (step) qn = (q == MAX) ? '0 : q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) q <= '0;
      else      q <= qn;
   end
endmodule

// File: rtl/alarm_clock_multi.sv
// Clock with day-of-week, NA day-masked alarms and one shared ring/snooze/timeout FSM.
module alarm_clock_multi
   import alarm_pkg::*;
#(
   parameter int NS       = 60,
   parameter int NH       = 24,
   parameter int ND       = 7,
   parameter int NA       = 4,
   parameter int SNZ_MIN  = 9,
   parameter int RING_SEC = 60,
   localparam int AW      = (NA > 1) ? $clog2(NA) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tick,
   input  logic            timeset,
   input  logic            alarmset,
   input  logic            minadv,
   input  logic            hrsadv,
   input  logic            dayadv,
   input  logic [AW-1:0]   alarm_sel,
   input  logic [NA-1:0]   alarm_on,
   input  logic [NA*ND-1:0] alarm_days,
   input  logic            snooze,
   input  logic            stop,
   output logic [TW-1:0]   disp_sec,
   output logic [TW-1:0]   disp_min,
   output logic [TW-1:0]   disp_hrs,
   output logic [DW-1:0]   disp_day,
   output logic            buzz,
   output logic [AW-1:0]   buzz_idx,
   output logic            snoozing
);
   localparam int RW = $clog2(RING_SEC + 1);
   localparam int SW = $clog2(SNZ_MIN * NS + 1);
   localparam logic [RW-1:0] RING_LOAD = RW'(RING_SEC);
   localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNZ_MIN * NS);

   if (NS < 2 || NS > 128 || NH < 2 || NH > 128 || ND < 2 || ND > 8 || NA < 1 || NA > 8)
   begin : g_bad_params
      $error("alarm_clock_multi: NS/NH must be 2..128, ND 2..8, NA 1..8");
   end

   mode_e mode;
   logic  tset, aset;
   always_comb begin
      mode = RUN;
      if (timeset && !alarmset)      mode = TSET;
      else if (alarmset && !timeset) mode = ASET;
   end
   assign tset = (mode == TSET);
   assign aset = (mode == ASET);

   logic [TW-1:0] sec, min, hrs, sec_n, min_n, hrs_n;
   logic [DW-1:0] day, day_n;
   logic          sec_co, min_co, hrs_co, day_co, unused_co;
   assign unused_co = day_co;

   // In set mode each field steps on its own button; otherwise carries chain
   mod_ctr_wrap #(.N(NS), .W(TW)) u_sec (.clk(clk), .rst(rst), .en(tick), .cin(!tset),
      .cout(sec_co), .q(sec), .qn(sec_n));
   mod_ctr_wrap #(.N(NS), .W(TW)) u_min (.clk(clk), .rst(rst), .en(tick),
      .cin(tset ? minadv : sec_co), .cout(min_co), .q(min), .qn(min_n));
   mod_ctr_wrap #(.N(NH), .W(TW)) u_hrs (.clk(clk), .rst(rst), .en(tick),
      .cin(tset ? hrsadv : min_co), .cout(hrs_co), .q(hrs), .qn(hrs_n));
   mod_ctr_wrap #(.N(ND), .W(DW)) u_day (.clk(clk), .rst(rst), .en(tick),
      .cin(tset ? dayadv : hrs_co), .cout(day_co), .q(day), .qn(day_n));

   logic [TW-1:0] amin [NA];
   logic [TW-1:0] ahrs [NA];
   logic [TW-1:0] amin_n [NA];
   logic [TW-1:0] ahrs_n [NA];
   logic [NA-1:0] hit;

   for (genvar k = 0; k < NA; k++) begin : g_alarm
      logic          sel, co_m, co_h, unused_a;
      logic [ND-1:0] mask;
      assign sel      = aset & (alarm_sel == AW'(k));
      assign unused_a = co_m ^ co_h;
      mod_ctr_wrap #(.N(NS), .W(TW)) u_amin (.clk(clk), .rst(rst), .en(tick),
         .cin(sel & minadv), .cout(co_m), .q(amin[k]), .qn(amin_n[k]));
      mod_ctr_wrap #(.N(NH), .W(TW)) u_ahrs (.clk(clk), .rst(rst), .en(tick),
         .cin(sel & hrsadv), .cout(co_h), .q(ahrs[k]), .qn(ahrs_n[k]));
      // Compare against the time this tick produces, not the time before it
      assign mask   = alarm_days[k*ND +: ND];
      assign hit[k] = alarm_on[k] & mask[day_n] & (amin[k] == min_n) & (ahrs[k] == hrs_n);
   end

   logic          trig;
   logic [AW-1:0] trig_idx;
   always_comb begin
      trig     = 1'b0;
      trig_idx = '0;
      if (mode == RUN && tick && sec_n == '0) begin
         for (int k = NA - 1; k >= 0; k--) begin
            if (hit[k]) begin
               trig     = 1'b1;
               trig_idx = AW'(k);
            end
         end
      end
   end

   ring_e         state;
   logic [RW-1:0] ring_t;
   logic [SW-1:0] snz_t;
   logic [NA-1:0] on_q;
   logic          fall;
   assign fall = on_q[buzz_idx] & ~alarm_on[buzz_idx];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         buzz_idx <= '0;
         ring_t   <= '0;
         snz_t    <= '0;
         on_q     <= '0;
      end else begin
         on_q <= alarm_on;
         case (state)
            IDLE: if (trig) begin
               state    <= RING;
               buzz_idx <= trig_idx;
               ring_t   <= RING_LOAD;
            end
            RING: begin
               if (fall || stop) state <= IDLE;
               else if (snooze) begin
                  state <= SNOOZE;
                  snz_t <= SNZ_LOAD;
               end else if (tick) begin
                  if (ring_t <= RW'(1)) state <= IDLE;
                  ring_t <= ring_t - 1'b1;
               end
            end
            SNOOZE: begin
               if (fall || stop) state <= IDLE;
               else if (trig) begin
                  state    <= RING;
                  buzz_idx <= trig_idx;
                  ring_t   <= RING_LOAD;
               end else if (tick) begin
                  if (snz_t <= SW'(1)) begin
                     state  <= RING;
                     ring_t <= RING_LOAD;
                  end
                  snz_t <= snz_t - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign buzz     = (state == RING);
   assign snoozing = (state == SNOOZE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         disp_sec <= '0;
         disp_min <= '0;
         disp_hrs <= '0;
         disp_day <= '0;
      end else begin
         disp_day <= day_n;
         if (aset) begin
            disp_sec <= '0;
            disp_min <= amin_n[alarm_sel];
            disp_hrs <= ahrs_n[alarm_sel];
         end else begin
            disp_sec <= sec_n;
            disp_min <= min_n;
            disp_hrs <= hrs_n;
         end
      end
   end
endmodule

// File: tb/tb_alarm_clock_multi.sv
// Bench for alarm_clock_multi: vector table, hand-built alarm sequences, and random traffic vs a seconds-of-week model.
module tb_alarm_clock_multi;
   localparam int WEEK = 7 * 24 * 3600;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick, timeset, alarmset, minadv, hrsadv, dayadv, snooze, stop;
   logic [1:0]  alarm_sel;
   logic [3:0]  alarm_on;
   logic [27:0] alarm_days;
   logic [6:0]  disp_sec, disp_min, disp_hrs;
   logic [2:0]  disp_day;
   logic        buzz, snoozing;
   logic [1:0]  buzz_idx;

   alarm_clock_multi dut (
      .clk(clk), .rst(rst), .tick(tick), .timeset(timeset), .alarmset(alarmset),
      .minadv(minadv), .hrsadv(hrsadv), .dayadv(dayadv), .alarm_sel(alarm_sel),
      .alarm_on(alarm_on), .alarm_days(alarm_days), .snooze(snooze), .stop(stop),
      .disp_sec(disp_sec), .disp_min(disp_min), .disp_hrs(disp_hrs), .disp_day(disp_day),
      .buzz(buzz), .buzz_idx(buzz_idx), .snoozing(snoozing)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit mchk = 1'b0;

   // Model: time as seconds since Sunday 00:00:00, ring as a mode plus seconds left
   int          m_t, rs, ridx, rleft, sleft;
   int          am [4];
   int          ah [4];
   logic [3:0]  on_prev;
   logic [27:0] exp_out;

   function automatic int f_s(); return m_t % 60; endfunction
   function automatic int f_m(); return (m_t / 60) % 60; endfunction
   function automatic int f_h(); return (m_t / 3600) % 24; endfunction
   function automatic int f_d(); return m_t / 86400; endfunction
   function automatic bit bitof(logic [31:0] v, int i); return v[i[4:0]]; endfunction

   function automatic logic [27:0] pack(int s, int m, int h, int d, int b, int i, int z);
      return {7'(s), 7'(m), 7'(h), 3'(d), 1'(b), 2'(i), 1'(z)};
   endfunction

   function automatic logic [27:0] outv();
      return {disp_sec, disp_min, disp_hrs, disp_day, buzz, buzz_idx, snoozing};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_t = 0; rs = 0; ridx = 0; rleft = 0; sleft = 0; on_prev = '0; exp_out = '0;
      for (int k = 0; k < 4; k++) begin am[k] = 0; ah[k] = 0; end
   endtask

   task automatic model_step();
      bit ts, as, run, trig, fall;
      int tk, nt, s, m, h, d;
      ts = timeset && !alarmset;
      as = alarmset && !timeset;
      run = !ts && !as;
      trig = 0; tk = 0;
      if (run && tick) begin
         nt = (m_t + 1) % WEEK;
         if (nt % 60 == 0)
            for (int k = 3; k >= 0; k--)
               if (alarm_on[k] && bitof(32'(alarm_days), k * 7 + nt / 86400) &&
                   ah[k] * 3600 + am[k] * 60 == nt % 86400) begin
                  trig = 1; tk = k;
               end
      end
      fall = (rs != 0) && bitof(32'(on_prev), ridx) && !bitof(32'(alarm_on), ridx);
      case (rs)
         0: if (trig) begin rs = 1; ridx = tk; rleft = 60; end
         1: begin
            if (fall || stop) rs = 0;
            else if (snooze) begin rs = 2; sleft = 540; end
            else if (tick) begin rleft--; if (rleft == 0) rs = 0; end
         end
         default: begin
            if (fall || stop) rs = 0;
            else if (trig) begin rs = 1; ridx = tk; rleft = 60; end
            else if (tick) begin sleft--; if (sleft == 0) begin rs = 1; rleft = 60; end end
         end
      endcase
      if (tick) begin
         if (ts) begin
            s = f_s();
            m = (f_m() + int'(minadv)) % 60;
            h = (f_h() + int'(hrsadv)) % 24;
            d = (f_d() + int'(dayadv)) % 7;
            m_t = s + 60 * m + 3600 * h + 86400 * d;
         end else m_t = (m_t + 1) % WEEK;
         if (as) begin
            am[alarm_sel] = (am[alarm_sel] + int'(minadv)) % 60;
            ah[alarm_sel] = (ah[alarm_sel] + int'(hrsadv)) % 24;
         end
      end
      on_prev = alarm_on;
      if (as) exp_out = pack(0, am[alarm_sel], ah[alarm_sel], f_d(), rs == 1, ridx, rs == 2);
      else    exp_out = pack(f_s(), f_m(), f_h(), f_d(), rs == 1, ridx, rs == 2);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (mchk) chk("model", 32'(outv()), 32'(exp_out));
   endtask

   task automatic clear_buttons();
      timeset = 0; alarmset = 0; minadv = 0; hrsadv = 0; dayadv = 0; snooze = 0; stop = 0;
   endtask

   task automatic set_time(int h, int m, int s, int d);
      clear_buttons(); tick = 1;
      repeat ((s - f_s() + 60) % 60) cycle();
      timeset = 1;
      hrsadv = 1; repeat ((h - f_h() + 24) % 24) cycle(); hrsadv = 0;
      minadv = 1; repeat ((m - f_m() + 60) % 60) cycle(); minadv = 0;
      dayadv = 1; repeat ((d - f_d() + 7) % 7) cycle(); dayadv = 0;
      timeset = 0;
   endtask

   task automatic set_alarm(int k, int h, int m);
      clear_buttons(); tick = 1; alarmset = 1; alarm_sel = 2'(k);
      hrsadv = 1; repeat ((h - ah[k] + 24) % 24) cycle(); hrsadv = 0;
      minadv = 1; repeat ((m - am[k] + 60) % 60) cycle(); minadv = 0;
      alarmset = 0;
   endtask

   typedef struct {
      int rep, ts, as, ma, ha, da, sel;
      int es, em, eh, ed;
   } vec_t;
   vec_t tbl [13];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_buttons(); tick = 0; alarm_sel = 0; alarm_on = 0; alarm_days = 0;
      model_reset();
      #3 rst = 0;
      #1 chk("reset_outputs", 32'(outv()), 32'd0);
      @(negedge clk); @(negedge clk);
      rst = 1; mchk = 1;

      //          rep ts as ma ha da sel  sec min hrs day
      tbl[0]  = '{23, 1, 0, 1, 1, 1, 0,   0, 23, 23, 2};
      tbl[1]  = '{ 4, 1, 0, 0, 0, 1, 0,   0, 23, 23, 6};
      tbl[2]  = '{36, 1, 0, 1, 0, 0, 0,   0, 59, 23, 6};
      tbl[3]  = '{59, 0, 0, 0, 0, 0, 0,  59, 59, 23, 6};
      tbl[4]  = '{ 1, 0, 0, 0, 0, 0, 0,   0,  0,  0, 0};
      tbl[5]  = '{30, 0, 0, 0, 0, 0, 0,  30,  0,  0, 0};
      tbl[6]  = '{10, 1, 0, 0, 1, 0, 0,  30,  0, 10, 0};
      tbl[7]  = '{58, 1, 0, 1, 0, 0, 0,  30, 58, 10, 0};
      tbl[8]  = '{ 3, 1, 0, 1, 1, 0, 0,  30,  1, 13, 0};
      tbl[9]  = '{ 1, 1, 1, 1, 1, 0, 0,  31,  1, 13, 0};
      tbl[10] = '{ 5, 1, 0, 0, 0, 0, 0,  31,  1, 13, 0};
      tbl[11] = '{ 7, 0, 1, 0, 1, 0, 2,   0,  0,  7, 0};
      tbl[12] = '{ 2, 0, 0, 0, 0, 0, 0,  40,  1, 13, 0};
      for (int i = 0; i < 13; i++) begin
         timeset = tbl[i].ts[0]; alarmset = tbl[i].as[0];
         minadv = tbl[i].ma[0]; hrsadv = tbl[i].ha[0]; dayadv = tbl[i].da[0];
         alarm_sel = 2'(tbl[i].sel); tick = 1;
         repeat (tbl[i].rep) cycle();
         chk($sformatf("vec%0d_time", i), 32'({disp_sec, disp_min, disp_hrs, disp_day}),
             32'({7'(tbl[i].es), 7'(tbl[i].em), 7'(tbl[i].eh), 3'(tbl[i].ed)}));
      end
      clear_buttons(); tick = 0;

      // Alarm 2 at 07:00 armed for day 1 only: trigger, snooze, re-ring, stop+snooze
      alarm_days = 28'h0008000;
      set_time(6, 59, 59, 1);
      alarm_on = 4'b0100; tick = 1; cycle();
      chk("trig_buzz", 32'({buzz, buzz_idx, snoozing}), 32'({1'b1, 2'd2, 1'b0}));
      chk("trig_disp", 32'({disp_sec, disp_min, disp_hrs, disp_day}), 32'({7'd0, 7'd0, 7'd7, 3'd1}));
      tick = 0; snooze = 1; cycle(); snooze = 0;
      chk("snooze_enter", 32'({buzz, snoozing}), 32'b01);
      tick = 1; repeat (539) cycle();
      chk("snooze_539", 32'({buzz, snoozing}), 32'b01);
      cycle();
      chk("snooze_540", 32'({buzz, snoozing}), 32'b10);
      tick = 0; stop = 1; snooze = 1; cycle(); stop = 0; snooze = 0;
      chk("stop_wins", 32'({buzz, snoozing}), 32'b00);

      alarm_on = 0;
      set_time(6, 59, 59, 2);
      alarm_on = 4'b0100; tick = 1; cycle();
      chk("wrong_day", 32'(buzz), 32'd0);

      // Alarms 0 and 3 both at 06:30 every day: lowest index wins, then ring timeout
      alarm_on = 0;
      set_alarm(0, 6, 30);
      set_alarm(3, 6, 30);
      alarm_days = 28'hFE0807F;
      set_time(6, 29, 59, 3);
      alarm_on = 4'b1001; tick = 1; cycle();
      chk("prio_idx", 32'({buzz, buzz_idx}), 32'({1'b1, 2'd0}));
      repeat (59) cycle();
      chk("ring_59", 32'(buzz), 32'd1);
      cycle();
      chk("ring_timeout", 32'(buzz), 32'd0);

      alarm_on = 0;
      set_time(6, 29, 59, 4);
      alarm_on = 4'b1001; tick = 1; cycle();
      chk("pre_reset_buzz", 32'(buzz), 32'd1);
      tick = 0;
      #2 rst = 0;
      #1 chk("async_reset", 32'(outv()), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1;

      alarm_on = 0;
      alarm_days = 28'($urandom) | 28'h0204081;
      for (int k = 0; k < 4; k++) set_alarm(k, 0, k + 1);
      alarm_on = 4'hF;
      for (int n = 0; n < 3000; n++) begin
         tick = ($urandom % 4) != 0;
         timeset = ($urandom % 24) == 0;
         alarmset = ($urandom % 24) == 0;
         minadv = ($urandom % 4) == 0;
         hrsadv = ($urandom % 4) == 0;
         dayadv = ($urandom % 4) == 0;
         alarm_sel = 2'($urandom % 4);
         snooze = ($urandom % 40) == 0;
         stop = ($urandom % 150) == 0;
         if ($urandom % 64 == 0) alarm_on = alarm_on ^ (4'b0001 << ($urandom % 4));
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
